// File: rtl/instr_ram_arbiter_if.sv
// Signal bundle between the instruction-RAM arbiter and its two masters plus the memory.
// slave = arbiter view, master = environment (core, bus, memory) view.
interface instr_ram_arbiter_if #(
   parameter int ADDR_WIDTH = 17
);
   logic                  instr_req_i;
   logic [31:0]           instr_addr_i;
   logic                  instr_gnt_o;
   logic                  instr_rvalid_o;
   logic [31:0]           instr_rdata_o;
   logic                  bus_req_i;
   logic                  bus_we_i;
   logic [3:0]            bus_be_i;
   logic [31:0]           bus_addr_i;
   logic [31:0]           bus_wdata_i;
   logic                  bus_gnt_o;
   logic                  bus_rvalid_o;
   logic [31:0]           bus_rdata_o;
   logic                  bus_err_o;
   logic                  ram_en_o;
   logic [ADDR_WIDTH-1:0] ram_addr_o;
   logic                  ram_we_o;
   logic [3:0]            ram_be_o;
   logic [31:0]           ram_wdata_o;
   logic [31:0]           ram_rdata_i;

   modport slave (
      input  instr_req_i, instr_addr_i,
      input  bus_req_i, bus_we_i, bus_be_i, bus_addr_i, bus_wdata_i,
      input  ram_rdata_i,
      output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
      output bus_gnt_o, bus_rvalid_o, bus_rdata_o, bus_err_o,
      output ram_en_o, ram_addr_o, ram_we_o, ram_be_o, ram_wdata_o
   );

   modport master (
      output instr_req_i, instr_addr_i,
      output bus_req_i, bus_we_i, bus_be_i, bus_addr_i, bus_wdata_i,
      output ram_rdata_i,
      input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
      input  bus_gnt_o, bus_rvalid_o, bus_rdata_o, bus_err_o,
      input  ram_en_o, ram_addr_o, ram_we_o, ram_be_o, ram_wdata_o
   );
endinterface

// File: rtl/instr_ram_arbiter.sv
// Core-fetch / bus arbiter in front of the single-port instruction memory, with a bus starvation guard.
// Optional boot-region write protection: define INSTR_RAM_ARB_BOOT_WP_EN.
module instr_ram_arbiter #(
   parameter int ADDR_WIDTH = 17,
   parameter int STALL_MAX  = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   instr_ram_arbiter_if.slave   port
);

   logic [3:0]  stall_cnt;
   logic        force_bus;
   logic        instr_gnt;
   logic        bus_gnt;
   logic        wp_hit;
   logic        vld_p1;
   logic        own_bus_p1;
   logic        wr_p1;
   logic        instr_rvalid;
   logic        bus_rvalid;
   logic [31:0] instr_hold_p1;
   logic [31:0] bus_hold_p1;

   // Request cycle: grant decision and memory drive
   always_comb begin
      force_bus = port.bus_req_i && (stall_cnt == 4'(STALL_MAX));
      bus_gnt   = !rst && port.bus_req_i && (!port.instr_req_i || force_bus);
      instr_gnt = !rst && port.instr_req_i && !bus_gnt;
`ifdef INSTR_RAM_ARB_BOOT_WP_EN
      wp_hit    = bus_gnt && port.bus_we_i && port.bus_addr_i[ADDR_WIDTH-1];
`else
      wp_hit    = 1'b0;
`endif
   end

   assign port.instr_gnt_o = instr_gnt;
   assign port.bus_gnt_o   = bus_gnt;
   assign port.ram_en_o    = instr_gnt || (bus_gnt && !wp_hit);
   assign port.ram_we_o    = bus_gnt && port.bus_we_i && !wp_hit;
   assign port.ram_addr_o  = bus_gnt ? port.bus_addr_i[ADDR_WIDTH-1:0]
                                     : port.instr_addr_i[ADDR_WIDTH-1:0];
   assign port.ram_be_o    = bus_gnt ? port.bus_be_i : 4'hF;
   assign port.ram_wdata_o = port.bus_wdata_i;

   // A granted request (or a dropped one) ends the bus's losing streak
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= 4'd0;
      end else if (!port.bus_req_i || bus_gnt) begin
         stall_cnt <= 4'd0;
      end else if (stall_cnt != 4'(STALL_MAX)) begin
         stall_cnt <= stall_cnt + 4'd1;
      end
   end

   // Response stage: owner flag and valid for the access issued last cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1     <= 1'b0;
         own_bus_p1 <= 1'b0;
         wr_p1      <= 1'b0;
      end else begin
         vld_p1     <= instr_gnt || bus_gnt;
         own_bus_p1 <= bus_gnt;
         wr_p1      <= bus_gnt && port.bus_we_i;
      end
   end

   assign instr_rvalid = !rst && vld_p1 && !own_bus_p1;
   assign bus_rvalid   = !rst && vld_p1 && own_bus_p1;

   always_ff @(posedge clk) begin
      if (rst) begin
         instr_hold_p1 <= 32'd0;
         bus_hold_p1   <= 32'd0;
      end else begin
         if (instr_rvalid) instr_hold_p1 <= port.ram_rdata_i;
         if (bus_rvalid && !wr_p1) bus_hold_p1 <= port.ram_rdata_i;
      end
   end

   assign port.instr_rvalid_o = instr_rvalid;
   assign port.bus_rvalid_o   = bus_rvalid;
   assign port.instr_rdata_o  = instr_rvalid ? port.ram_rdata_i : instr_hold_p1;
   assign port.bus_rdata_o    = (bus_rvalid && !wr_p1) ? port.ram_rdata_i : bus_hold_p1;

`ifdef INSTR_RAM_ARB_BOOT_WP_EN
   logic err_p1;

   always_ff @(posedge clk) begin
      if (rst) err_p1 <= 1'b0;
      else     err_p1 <= wp_hit;
   end

   assign port.bus_err_o = bus_rvalid && err_p1;
`else
   assign port.bus_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_instr_ram_arbiter.sv
// Directed vector bench for instr_ram_arbiter (ADDR_WIDTH=17, STALL_MAX=4).
module tb_instr_ram_arbiter;

`ifdef INSTR_RAM_ARB_BOOT_WP_EN
   localparam bit WP = 1'b1;
`else
   localparam bit WP = 1'b0;
`endif

   logic clk;
   logic rst;
   int   n_chk;
   int   n_fail;

   instr_ram_arbiter_if #(.ADDR_WIDTH(17)) bif ();

   instr_ram_arbiter #(.ADDR_WIDTH(17), .STALL_MAX(4)) dut (
      .clk  (clk),
      .rst  (rst),
      .port (bif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        ireq;
      logic [31:0] iaddr;
      logic        breq;
      logic        bwe;
      logic [3:0]  bbe;
      logic [31:0] baddr;
      logic [31:0] bwd;
      logic [31:0] rd;
      logic        e_ig;
      logic        e_bg;
      logic        e_irv;
      logic        e_brv;
      logic [31:0] e_ird;
      logic [31:0] e_brd;
      logic        e_en;
      logic        e_we;
      logic [16:0] e_addr;
      logic [3:0]  e_be;
      logic [31:0] e_wd;
      logic        e_err;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(
      logic r, logic ireq, logic [31:0] iaddr, logic breq, logic bwe, logic [3:0] bbe,
      logic [31:0] baddr, logic [31:0] bwd, logic [31:0] rd,
      logic ig, logic bg, logic irv, logic brv, logic [31:0] ird, logic [31:0] brd,
      logic en, logic we, logic [16:0] addr, logic [3:0] be, logic [31:0] wd, logic err);
      vec_t v;
      v.rst = r; v.ireq = ireq; v.iaddr = iaddr; v.breq = breq; v.bwe = bwe; v.bbe = bbe;
      v.baddr = baddr; v.bwd = bwd; v.rd = rd;
      v.e_ig = ig; v.e_bg = bg; v.e_irv = irv; v.e_brv = brv; v.e_ird = ird; v.e_brd = brd;
      v.e_en = en; v.e_we = we; v.e_addr = addr; v.e_be = be; v.e_wd = wd; v.e_err = err;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      rst             = v.rst;
      bif.instr_req_i  = v.ireq;
      bif.instr_addr_i = v.iaddr;
      bif.bus_req_i    = v.breq;
      bif.bus_we_i     = v.bwe;
      bif.bus_be_i     = v.bbe;
      bif.bus_addr_i   = v.baddr;
      bif.bus_wdata_i  = v.bwd;
      bif.ram_rdata_i  = v.rd;
   endtask

   task automatic check_row(input int i, input vec_t v);
      chk($sformatf("r%0d instr_gnt", i),    32'(bif.instr_gnt_o),    32'(v.e_ig));
      chk($sformatf("r%0d bus_gnt", i),      32'(bif.bus_gnt_o),      32'(v.e_bg));
      chk($sformatf("r%0d instr_rvalid", i), 32'(bif.instr_rvalid_o), 32'(v.e_irv));
      chk($sformatf("r%0d bus_rvalid", i),   32'(bif.bus_rvalid_o),   32'(v.e_brv));
      chk($sformatf("r%0d instr_rdata", i),  bif.instr_rdata_o,       v.e_ird);
      chk($sformatf("r%0d bus_rdata", i),    bif.bus_rdata_o,         v.e_brd);
      chk($sformatf("r%0d ram_en", i),       32'(bif.ram_en_o),       32'(v.e_en));
      chk($sformatf("r%0d ram_we", i),       32'(bif.ram_we_o),       32'(v.e_we));
      chk($sformatf("r%0d bus_err", i),      32'(bif.bus_err_o),      32'(v.e_err));
      if (v.e_en) begin
         chk($sformatf("r%0d ram_addr", i), 32'(bif.ram_addr_o), 32'(v.e_addr));
         chk($sformatf("r%0d ram_be", i),   32'(bif.ram_be_o),   32'(v.e_be));
      end
      if (v.e_we) chk($sformatf("r%0d ram_wdata", i), bif.ram_wdata_o, v.e_wd);
   endtask

   initial begin
      logic [31:0] ih, bh, rdv;
      logic        bg, irv, brv, prev_bg;
      vec_t        idle;

      n_chk  = 0;
      n_fail = 0;
      idle   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
      apply(idle);
      rst = 1'b1;

      // Reset held with both requests active
      for (int k = 0; k < 3; k++)
         tbl.push_back(mk(1, 1, 32'h100, 1, 0, 4'hF, 32'h200, 0, 32'h5A5A5A5A,
                          0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      // Core fetch, response, hold
      tbl.push_back(mk(0, 1, 32'h0000_0100, 0, 0, 0, 0, 0, 0,
                       1, 0, 0, 0, 0, 0, 1, 0, 17'h00100, 4'hF, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF,
                       0, 0, 1, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h11111111,
                       0, 0, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0));
      // Bus write; its response leaves bus_rdata untouched
      tbl.push_back(mk(0, 0, 0, 1, 1, 4'b0011, 32'h40, 32'h12345678, 0,
                       0, 1, 0, 0, 32'hDEADBEEF, 0, 1, 1, 17'h00040, 4'b0011, 32'h12345678, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'hAAAA5555,
                       0, 0, 0, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0));
      // Interleave: core then bus read on consecutive cycles
      tbl.push_back(mk(0, 1, 32'h204, 0, 0, 0, 0, 0, 0,
                       1, 0, 0, 0, 32'hDEADBEEF, 0, 1, 0, 17'h00204, 4'hF, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 4'hF, 32'h308, 0, 32'h0000C0DE,
                       0, 1, 1, 0, 32'h0000C0DE, 0, 1, 0, 17'h00308, 4'hF, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'hB0B0B0B0,
                       0, 0, 0, 1, 32'h0000C0DE, 32'hB0B0B0B0, 0, 0, 0, 0, 0, 0));
      // Upper address bits alias away
      tbl.push_back(mk(0, 1, 32'hFFFE_0010, 0, 0, 0, 0, 0, 0,
                       1, 0, 0, 0, 32'h0000C0DE, 32'hB0B0B0B0, 1, 0, 17'h00010, 4'hF, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h12,
                       0, 0, 1, 0, 32'h12, 32'hB0B0B0B0, 0, 0, 0, 0, 0, 0));
      // Contention: bus wins every fifth cycle
      ih = 32'h12; bh = 32'hB0B0B0B0; prev_bg = 1'b0;
      for (int j = 0; j < 10; j++) begin
         bg  = (j % 5 == 4);
         rdv = 32'hC000_0000 + 32'(j);
         irv = (j > 0) && !prev_bg;
         brv = (j > 0) && prev_bg;
         if (irv) ih = rdv;
         if (brv) bh = rdv;
         tbl.push_back(mk(0, 1, 32'h400, 1, 0, 4'hF, 32'h800, 0, rdv,
                          !bg, bg, irv, brv, ih, bh, 1, 0, bg ? 17'h00800 : 17'h00400, 4'hF, 0, 0));
         prev_bg = bg;
      end
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'hD0D0D0D0,
                       0, 0, 0, 1, 32'hC0000009, 32'hD0D0D0D0, 0, 0, 0, 0, 0, 0));
      // Boot-region write
      tbl.push_back(mk(0, 0, 0, 1, 1, 4'hF, 32'h0001_0000, 32'hCAFEF00D, 0,
                       0, 1, 0, 0, 32'hC0000009, 32'hD0D0D0D0, !WP, !WP, 17'h10000, 4'hF,
                       32'hCAFEF00D, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h77,
                       0, 0, 0, 1, 32'hC0000009, 32'hD0D0D0D0, 0, 0, 0, 0, 0, WP));
      // Stall counter clears when the bus drops its request
      tbl.push_back(mk(0, 1, 32'h400, 1, 0, 4'hF, 32'h800, 0, 0,
                       1, 0, 0, 0, 32'hC0000009, 32'hD0D0D0D0, 1, 0, 17'h00400, 4'hF, 0, 0));
      for (int k = 0; k < 2; k++)
         tbl.push_back(mk(0, 1, 32'h400, 1, 0, 4'hF, 32'h800, 0, 0,
                          1, 0, 1, 0, 0, 32'hD0D0D0D0, 1, 0, 17'h00400, 4'hF, 0, 0));
      tbl.push_back(mk(0, 1, 32'h400, 0, 0, 4'hF, 32'h800, 0, 0,
                       1, 0, 1, 0, 0, 32'hD0D0D0D0, 1, 0, 17'h00400, 4'hF, 0, 0));
      for (int k = 0; k < 4; k++)
         tbl.push_back(mk(0, 1, 32'h400, 1, 0, 4'hF, 32'h800, 0, 0,
                          1, 0, 1, 0, 0, 32'hD0D0D0D0, 1, 0, 17'h00400, 4'hF, 0, 0));
      tbl.push_back(mk(0, 1, 32'h400, 1, 0, 4'hF, 32'h800, 0, 0,
                       0, 1, 1, 0, 0, 32'hD0D0D0D0, 1, 0, 17'h00800, 4'hF, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h99,
                       0, 0, 0, 1, 0, 32'h99, 0, 0, 0, 0, 0, 0));

      @(negedge clk);
      foreach (tbl[i]) begin
         @(negedge clk);
         apply(tbl[i]);
         #4;
         check_row(i, tbl[i]);
      end

      // Reset lands while a fetch response is pending
      @(negedge clk);
      apply(idle);
      bif.instr_req_i  = 1'b1;
      bif.instr_addr_i = 32'h500;
      #4;
      chk("mid-rst grant", 32'(bif.instr_gnt_o), 32'd1);
      @(negedge clk);
      apply(idle);
      rst             = 1'b1;
      bif.ram_rdata_i = 32'h55;
      #4;
      chk("mid-rst rvalid in reset", 32'(bif.instr_rvalid_o), 32'd0);
      @(negedge clk);
      apply(idle);
      bif.ram_rdata_i = 32'h66;
      #4;
      chk("post-rst instr_rvalid", 32'(bif.instr_rvalid_o), 32'd0);
      chk("post-rst bus_rvalid",   32'(bif.bus_rvalid_o),   32'd0);
      chk("post-rst instr_rdata",  bif.instr_rdata_o,       32'd0);
      chk("post-rst bus_rdata",    bif.bus_rdata_o,         32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
